// File: rtl/boolexp_sweep_ctrl_pkg.sv
// Shared definitions for the Boolean-expression sweep controller.
//   state_e     : controller FSM encoding (IDLE=0, RUN=1, DONE=2)
//   NUM_VECTORS : number of input combinations of the 3-input block
//   IDX_W       : width of the vector index
package boolexp_sweep_ctrl_pkg;

    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned IDX_W       = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/boolexp_sweep_ctrl_if.sv
// Signal bundle between the sweep controller and its surroundings
// (the launching logic and the Boolean datapath under test).
//   start, abort         : sweep control requests
//   y                    : datapath output fed back to the controller
//   a, b, c              : registered stimulus to the datapath
//   busy, done           : sweep status, done is a one-cycle pulse
//   table_out            : captured truth table, bit i is y for {a,b,c} = i
//   pass, err_mask       : comparison of table_out against the expected table
// The slave modport is the controller; master is everything around it.
interface boolexp_sweep_ctrl_if;
    import boolexp_sweep_ctrl_pkg::*;

    logic                   start;
    logic                   abort;
    logic                   y;
    logic                   a;
    logic                   b;
    logic                   c;
    logic                   busy;
    logic                   done;
    logic [NUM_VECTORS-1:0] table_out;
    logic                   pass;
    logic [NUM_VECTORS-1:0] err_mask;

    modport master (
        output start, abort, y,
        input  a, b, c, busy, done, table_out, pass, err_mask
    );

    modport slave (
        input  start, abort, y,
        output a, b, c, busy, done, table_out, pass, err_mask
    );

endinterface

// File: rtl/boolexp_sweep_ctrl_settle_timer.sv
// settle_timer: free-running settle counter with a parameterised terminal count.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : hold the counter at zero
//   tick       : high during the last cycle of each TERMINAL_COUNT-cycle period
module settle_timer #(
    parameter int unsigned TERMINAL_COUNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(TERMINAL_COUNT) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL_COUNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/boolexp_sweep_ctrl.sv
// boolexp_sweep_ctrl: drives a 3-input Boolean block through all eight input
// combinations, holds each for SETTLE_CYCLES cycles, samples y on the last
// cycle of each vector and reports the truth table against EXPECTED.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of boolexp_sweep_ctrl_if (start/abort/y in,
//                a/b/c, busy, done, table_out, pass, err_mask out)
module boolexp_sweep_ctrl
    import boolexp_sweep_ctrl_pkg::*;
#(
    parameter int unsigned            SETTLE_CYCLES = 4,
    parameter logic [NUM_VECTORS-1:0] EXPECTED      = 8'hE8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    boolexp_sweep_ctrl_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_VECTORS-1:0] table_q, table_d;
    logic                   pass_q, pass_d;
    logic [NUM_VECTORS-1:0] err_q, err_d;
    logic                   tick;

    // Counter runs only in RUN, so it is already zero on entry to RUN.
    settle_timer #(
        .TERMINAL_COUNT (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q != StRun),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        table_d = table_q;
        pass_d  = pass_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                // abort outranks start even when idle
                if (bus.start && !bus.abort) begin
                    state_d = StRun;
                    idx_d   = '0;
                    table_d = '0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                end
            end
            StRun: begin
                if (bus.abort) begin
                    // Partial capture is kept; the final capture is dropped too.
                    state_d = StIdle;
                    idx_d   = '0;
                end else if (tick) begin
                    table_d[idx_q] = bus.y;
                    idx_d          = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        // Verdict uses the table including the bit captured now.
                        state_d = StDone;
                        pass_d  = (table_d == EXPECTED);
                        err_d   = table_d ^ EXPECTED;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            table_q <= table_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
        end
    end

    // idx wraps to 0 on the last capture and is cleared on abort, so the
    // stimulus is already 000 whenever the controller leaves RUN.
    assign bus.a         = idx_q[2];
    assign bus.b         = idx_q[1];
    assign bus.c         = idx_q[0];
    assign bus.busy      = (state_q == StRun);
    assign bus.done      = (state_q == StDone);
    assign bus.table_out = table_q;
    assign bus.pass      = pass_q;
    assign bus.err_mask  = err_q;

endmodule
